// File: rtl/tohost_monitor_if.sv
// Uncached MMIO write channel between the DUT and the tohost monitor:
// a request/acknowledge pair with one write outstanding at a time.
interface tohost_monitor_if #(
  parameter int ADDR_W = 32
);
  logic              io_req_valid;
  logic              io_req_ready;
  logic [ADDR_W-1:0] io_req_addr;
  logic [63:0]       io_req_data;
  logic [7:0]        io_req_mask;
  logic              io_resp_valid;
  logic              io_resp_ready;

  modport master (
    output io_req_valid, io_req_addr, io_req_data, io_req_mask, io_resp_ready,
    input  io_req_ready, io_resp_valid
  );

  modport slave (
    input  io_req_valid, io_req_addr, io_req_data, io_req_mask, io_resp_ready,
    output io_req_ready, io_resp_valid
  );
endinterface

// File: rtl/tohost_monitor.sv
// Decodes riscv-tests tohost writes into sticky pass/fail flags and runs a
// forward-progress watchdog that converts a hung DUT into a coded failure.
module tohost_monitor #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h8000_1000),
  parameter int                WD_W        = 32
) (
  input  logic                clock,
  input  logic                reset,
  tohost_monitor_if.slave     bus,
  input  logic                io_commit,
  input  logic [WD_W-1:0]     io_wd_limit,
  output logic                io_success,
  output logic                io_failure,
  output logic [31:0]         io_fail_code
);

  typedef enum logic [1:0] {S_RUN, S_RESP, S_PASS, S_FAIL} state_e;

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [63:0]     tohost_q, tohost_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            success_q, success_d;
  logic            failure_q, failure_d;
  logic [31:0]     fail_code_q, fail_code_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;

  logic [63:0]     merged;
  logic [WD_W:0]   wd_inc;
  logic            accept, ack_done, hit, decide, expire, terminal_d;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    tohost_d    = tohost_q;
    wd_d        = wd_q;
    success_d   = success_q;
    failure_d   = failure_q;
    fail_code_d = fail_code_q;

    merged = tohost_q;
    for (int b = 0; b < 8; b++) begin
      if (bus.io_req_mask[b]) merged[8*b +: 8] = bus.io_req_data[8*b +: 8];
    end

    accept   = bus.io_req_valid && req_ready_q;
    ack_done = resp_valid_q && bus.io_resp_ready;
    hit      = (bus.io_req_addr == TOHOST_ADDR);
    decide   = accept && hit && bus.io_req_mask[0] && merged[0];
    wd_inc   = {1'b0, wd_q} + (WD_W+1)'(1);
    expire   = (io_wd_limit != '0) && !io_commit && (wd_inc >= {1'b0, io_wd_limit});

    unique case (state_q)
      S_RUN, S_RESP: begin
        if (io_commit)        wd_d = '0;
        else if (!wd_inc[WD_W]) wd_d = wd_inc[WD_W-1:0];
        if (accept && hit) tohost_d = merged;

        // A tohost decision outranks a watchdog expiry in the same cycle.
        if (decide) begin
          pend_d = 1'b1;
          if (merged == 64'd1) begin
            state_d   = S_PASS;
            success_d = 1'b1;
          end else begin
            state_d     = S_FAIL;
            failure_d   = 1'b1;
            fail_code_d = merged[32:1];
          end
        end else if (expire) begin
          state_d     = S_FAIL;
          failure_d   = 1'b1;
          fail_code_d = 32'hFFFF_FFFF;
          pend_d      = accept || ((state_q == S_RESP) && !ack_done);
        end else if (accept) begin
          state_d = S_RESP;
        end else if ((state_q == S_RESP) && ack_done) begin
          state_d = S_RUN;
        end
      end
      default: begin
        // Terminal: keep acknowledging traffic, everything else frozen.
        if (pend_q) begin
          if (ack_done) pend_d = 1'b0;
        end else if (accept) begin
          pend_d = 1'b1;
        end
      end
    endcase

    terminal_d   = (state_d == S_PASS) || (state_d == S_FAIL);
    req_ready_d  = (state_d == S_RUN) || (terminal_d && !pend_d);
    resp_valid_d = (state_d == S_RESP) || (terminal_d && pend_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RUN;
      pend_q       <= 1'b0;
      tohost_q     <= '0;
      wd_q         <= '0;
      success_q    <= 1'b0;
      failure_q    <= 1'b0;
      fail_code_q  <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      tohost_q     <= tohost_d;
      wd_q         <= wd_d;
      success_q    <= success_d;
      failure_q    <= failure_d;
      fail_code_q  <= fail_code_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.io_req_ready  = req_ready_q;
  assign bus.io_resp_valid = resp_valid_q;
  assign io_success        = success_q;
  assign io_failure        = failure_q;
  assign io_fail_code      = fail_code_q;

endmodule
